// File: rtl/unary_pkg.sv
// Shared types and width helpers for the unary dot-product datapath.
package unary_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int calcChW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The total never wraps: N*(2^WIDTH-1)^2 always fits in 2*WIDTH plus the channel bits.
    function automatic int calcAccW(input int width, input int n);
        return 2 * width + calcChW(n);
    endfunction

endpackage

// File: rtl/unary_down_counter.sv
// Loadable down counter; load beats recycle, and recycle beats decrement.
module unary_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_load,
    input  logic             i_recycle,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_q0,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_recycle) begin
            r_q <= i_q0;
        end else if (i_en) begin
            r_q <= r_q - 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/unary_dot_product.sv
// Streams sum(w_i*x_i) as unary pulses on out, one channel at a time, with a binary running total.
module unary_dot_product
    import unary_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int N     = 4,
    localparam int CH_W  = calcChW(N),
    localparam int ACC_W = calcAccW(WIDTH, N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] w [N],
    input  logic [WIDTH-1:0] x [N],
    output logic             out,
    output logic             busy,
    output logic [CH_W-1:0]  ch_idx,
    output logic [ACC_W-1:0] total,
    output logic             done
);

    typedef logic [WIDTH-1:0] operand_t;

    state_t           r_state;
    state_t           w_nextState;
    operand_t         r_w [N];
    operand_t         r_x [N];
    logic [CH_W-1:0]  r_ch;
    logic [ACC_W-1:0] r_total;

    logic [CH_W-1:0]  w_nextCh;
    operand_t         w_curW;
    operand_t         w_curX;
    logic             w_zeroCh;
    logic             w_isLast;
    logic             w_accept;
    logic             w_chEnd;
    logic             w_load;
    logic             w_topEn;
    logic             w_botEn;
    logic             w_botRecycle;
    operand_t         w_loadW;
    operand_t         w_loadX;
    operand_t         w_topQ;
    operand_t         w_botQ;
    logic             w_out;

    assign w_curW   = r_w[r_ch];
    assign w_curX   = r_x[r_ch];
    assign w_zeroCh = (w_curW == '0) || (w_curX == '0);
    assign w_isLast = (r_ch == CH_W'(N - 1));
    assign w_nextCh = w_isLast ? '0 : r_ch + 1'b1;
    assign w_accept = in_valid && (r_state == IDLE);
    assign w_out    = (r_state == RUN) && !w_zeroCh;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The counters for the next channel load on the same edge the current channel ends, so there are no bubbles.
    always_comb begin
        w_nextState  = r_state;
        w_chEnd      = 1'b0;
        w_load       = 1'b0;
        w_topEn      = 1'b0;
        w_botEn      = 1'b0;
        w_botRecycle = 1'b0;
        w_loadW      = r_w[w_nextCh];
        w_loadX      = r_x[w_nextCh];
        case (r_state)
            IDLE: begin
                w_loadW = w[0];
                w_loadX = x[0];
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_zeroCh) begin
                    w_chEnd = 1'b1;
                end else if (w_botQ > WIDTH'(1)) begin
                    w_botEn = 1'b1;
                end else if (w_topQ > WIDTH'(1)) begin
                    w_topEn      = 1'b1;
                    w_botRecycle = 1'b1;
                end else begin
                    w_chEnd = 1'b1;
                end
                if (w_chEnd) begin
                    if (w_isLast) begin
                        w_nextState = DONE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch    <= '0;
            r_total <= '0;
            for (int i = 0; i < N; i++) begin
                r_w[i] <= '0;
                r_x[i] <= '0;
            end
        end else if (w_accept) begin
            r_ch    <= '0;
            r_total <= '0;
            for (int i = 0; i < N; i++) begin
                r_w[i] <= w[i];
                r_x[i] <= x[i];
            end
        end else begin
            if (w_out) begin
                r_total <= r_total + 1'b1;
            end
            if ((r_state == RUN) && w_chEnd && !w_isLast) begin
                r_ch <= w_nextCh;
            end
        end
    end

    unary_down_counter #(
        .WIDTH(WIDTH)
    ) u_topCounter (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_topEn),
        .i_load   (w_load),
        .i_recycle(1'b0),
        .i_d      (w_loadW),
        .i_q0     ('0),
        .o_q      (w_topQ)
    );

    // The bottom counter reloads the current activation each time the top counter steps down.
    unary_down_counter #(
        .WIDTH(WIDTH)
    ) u_botCounter (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_botEn),
        .i_load   (w_load),
        .i_recycle(w_botRecycle),
        .i_d      (w_loadX),
        .i_q0     (w_curX),
        .o_q      (w_botQ)
    );

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign out      = w_out;
    assign ch_idx   = r_ch;
    assign total    = r_total;

endmodule
